// File: rtl/vga_timing_out.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_out
//  Description : 640x480@60 pixel-timing generator with registered, blanked
//                colour output, aligned sync pulses and frame markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_out #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_ce,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    input  logic [3:0] r_in,
    input  logic [3:0] g_in,
    input  logic [3:0] b_in,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [9:0] c_h_last     = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last     = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_active   = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_active   = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_end     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_end     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_div_w-1:0] r_div;
    logic [9:0]         r_h_cnt;
    logic [9:0]         r_v_cnt;
    logic [3:0]         r_vga_r;
    logic [3:0]         r_vga_g;
    logic [3:0]         r_vga_b;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_frame_start;
    logic [7:0]         r_frame_cnt;

    logic w_pix_ce;
    logic w_valid;
    logic w_h_last;
    logic w_v_last;
    logic w_frame_wrap;
    logic w_hsync_n;
    logic w_vsync_n;

    // With CLK_DIV=1 the divider never leaves 0 and pix_ce is held high.
    assign w_pix_ce     = (r_div == c_div_last);
    assign w_valid      = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
    assign w_h_last     = (r_h_cnt == c_h_last);
    assign w_v_last     = (r_v_cnt == c_v_last);
    assign w_frame_wrap = w_pix_ce && w_h_last && w_v_last;
    assign w_hsync_n    = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
    assign w_vsync_n    = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_pix_ce) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_pix_ce) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Output stage registers the position currently presented, so colour and
    // syncs leave together one pixel period after the counters showed them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vga_r <= '0;
            r_vga_g <= '0;
            r_vga_b <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (w_pix_ce) begin
            r_vga_r <= w_valid ? r_in : 4'd0;
            r_vga_g <= w_valid ? g_in : 4'd0;
            r_vga_b <= w_valid ? b_in : 4'd0;
            r_hsync <= w_hsync_n;
            r_vsync <= w_vsync_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign pix_ce      = w_pix_ce;
    assign h_cnt       = r_h_cnt;
    assign v_cnt       = r_v_cnt;
    assign valid       = w_valid;
    assign vga_r       = r_vga_r;
    assign vga_g       = r_vga_g;
    assign vga_b       = r_vga_b;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
